// File: rtl/error_injector_param_pkg.sv
`default_nettype none
// ==================================================================
// Package : crc_pkg
// Brief   : Injection modes and default widths shared by tx/rx/injector.
// Rev     : 1.0
// ==================================================================
package crc_pkg;

  typedef enum logic [1:0] {
    BYPASS  = 2'd0,
    FIXED   = 2'd1,
    ONESHOT = 2'd2,
    WALK    = 2'd3
  } errMode_t;

  localparam int c_cw_width  = 32;
  localparam int c_cnt_width = 16;

  // True when the stored vector is applied to the current codeword.
  function automatic logic mode_applies(input errMode_t mode, input logic armed);
    logic applies;
    applies = 1'b1;
    case (mode)
      BYPASS:  applies = 1'b0;
      ONESHOT: applies = armed;
      default: applies = 1'b1;
    endcase
    return applies;
  endfunction

endpackage
`default_nettype wire

// File: rtl/error_injector_param_if.sv
`default_nettype none
// ==================================================================
// Interface : error_injector_param_if
// Brief     : Codeword stream, error-vector control and status bundle.
// Rev       : 1.0
// ==================================================================
interface error_injector_param_if
  import crc_pkg::*;
#(
  parameter int CW_WIDTH  = c_cw_width,
  parameter int CNT_WIDTH = c_cnt_width
);

  logic                 erLoad;
  logic [CW_WIDTH-1:0]  erIn;
  errMode_t             mode;
  logic                 clrCount;
  logic                 CWValid;
  logic [CW_WIDTH-1:0]  CW;
  logic                 endMsgIn;
  logic [CW_WIDTH-1:0]  erCW;
  logic                 erCWValid;
  logic                 endMsgOut;
  logic [CNT_WIDTH-1:0] injCount;
  logic                 armed;

  modport master (
    output erLoad, erIn, mode, clrCount, CWValid, CW, endMsgIn,
    input  erCW, erCWValid, endMsgOut, injCount, armed
  );

  modport slave (
    input  erLoad, erIn, mode, clrCount, CWValid, CW, endMsgIn,
    output erCW, erCWValid, endMsgOut, injCount, armed
  );

endinterface
`default_nettype wire

// File: rtl/error_injector_param_sat_counter.sv
`default_nettype none
// ==================================================================
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones; clear beats increment.
// Rev    : 1.0
// ==================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic             w_full;

  assign w_full = &r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !w_full) begin
      r_count <= r_count + c_one;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/error_injector_param.sv
`default_nettype none
// ==================================================================
// Module : error_injector_param
// Brief  : One-cycle codeword pipe that XORs a programmable error vector.
// Rev    : 1.0
// ==================================================================
module error_injector_param
  import crc_pkg::*;
#(
  parameter int CW_WIDTH  = c_cw_width,
  parameter int CNT_WIDTH = c_cnt_width
) (
  input  logic                 clk,
  input  logic                 rst,
  error_injector_param_if.slave bus
);

  logic [CW_WIDTH-1:0]  r_vec;
  logic [CW_WIDTH-1:0]  w_vec_nxt;
  logic                 r_armed;
  logic                 w_armed_nxt;
  logic [CW_WIDTH-1:0]  w_err;
  logic                 w_inject;
  logic [CW_WIDTH-1:0]  r_er_cw;
  logic                 r_er_cw_valid;
  logic                 r_end_msg;
  logic [CNT_WIDTH-1:0] w_count;

  // Error applied to this cycle's codeword, always from the pre-load vector.
  always_comb begin
    w_err = '0;
    if (mode_applies(bus.mode, r_armed)) begin
      w_err = r_vec;
    end
  end

  assign w_inject = bus.CWValid && (w_err != '0);

  // Later assignments win: a load overrides both disarm and rotation.
  always_comb begin
    w_vec_nxt   = r_vec;
    w_armed_nxt = r_armed;
    if (bus.CWValid && (bus.mode == ONESHOT) && r_armed) begin
      w_armed_nxt = 1'b0;
    end
    if (bus.CWValid && (bus.mode == WALK)) begin
      w_vec_nxt = {r_vec[CW_WIDTH-2:0], r_vec[CW_WIDTH-1]};
    end
    if (bus.erLoad) begin
      w_vec_nxt   = bus.erIn;
      w_armed_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vec   <= '0;
      r_armed <= 1'b0;
    end else begin
      r_vec   <= w_vec_nxt;
      r_armed <= w_armed_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_er_cw       <= '0;
      r_er_cw_valid <= 1'b0;
      r_end_msg     <= 1'b0;
    end else begin
      if (bus.CWValid) begin
        r_er_cw <= bus.CW ^ w_err;
      end
      r_er_cw_valid <= bus.CWValid;
      r_end_msg     <= bus.CWValid & bus.endMsgIn;
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_inj_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_inject),
    .clr   (bus.clrCount),
    .count (w_count)
  );

  assign bus.erCW      = r_er_cw;
  assign bus.erCWValid = r_er_cw_valid;
  assign bus.endMsgOut = r_end_msg;
  assign bus.injCount  = w_count;
  assign bus.armed     = r_armed;

endmodule
`default_nettype wire

// File: tb/tb_error_injector_param.sv
`default_nettype none
// ==================================================================
// Module : tb_error_injector_param
// Brief  : Random + directed bench against a rule-level reference model.
// Rev    : 1.0
// ==================================================================
module tb_error_injector_param;
  import crc_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         erLoad, clrCount, CWValid, endMsgIn;
  logic [W-1:0] erIn, CW;
  errMode_t     mode;

  error_injector_param_if #(.CW_WIDTH(W), .CNT_WIDTH(16)) bus0 ();
  error_injector_param_if #(.CW_WIDTH(W), .CNT_WIDTH(4))  bus4 ();

  assign bus0.erLoad   = erLoad;   assign bus4.erLoad   = erLoad;
  assign bus0.erIn     = erIn;     assign bus4.erIn     = erIn;
  assign bus0.mode     = mode;     assign bus4.mode     = mode;
  assign bus0.clrCount = clrCount; assign bus4.clrCount = clrCount;
  assign bus0.CWValid  = CWValid;  assign bus4.CWValid  = CWValid;
  assign bus0.CW       = CW;       assign bus4.CW       = CW;
  assign bus0.endMsgIn = endMsgIn; assign bus4.endMsgIn = endMsgIn;

  error_injector_param #(.CW_WIDTH(W), .CNT_WIDTH(16)) dut (
    .clk (clk), .rst (rst), .bus (bus0)
  );

  error_injector_param #(.CW_WIDTH(W), .CNT_WIDTH(4)) dut4 (
    .clk (clk), .rst (rst), .bus (bus4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: stored vector, one-shot flag, unbounded hit count.
  logic [W-1:0] m_vec, m_cw;
  bit           m_armed, m_valid, m_end;
  int           m_hits;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vec = '0; m_cw = '0; m_armed = 0; m_valid = 0; m_end = 0; m_hits = 0;
  endtask

  task automatic model_step();
    logic [W-1:0] e;
    if (!rst) begin
      model_reset();
      return;
    end
    e = '0;
    if (mode == FIXED || mode == WALK)  e = m_vec;
    if (mode == ONESHOT && m_armed)     e = m_vec;
    if (CWValid) m_cw = CW ^ e;
    m_valid = CWValid;
    m_end   = CWValid && endMsgIn;
    if (clrCount)                 m_hits = 0;
    else if (CWValid && e != '0)  m_hits++;
    if (erLoad) begin
      m_vec   = erIn;
      m_armed = 1;
    end else begin
      if (CWValid && mode == ONESHOT) m_armed = 0;
      if (CWValid && mode == WALK)    m_vec = (m_vec << 1) | (m_vec >> (W-1));
    end
  endtask

  task automatic compare_all();
    int e16, e4;
    e16 = (m_hits > 65535) ? 65535 : m_hits;
    e4  = (m_hits > 15) ? 15 : m_hits;
    check("erCW",       64'(bus0.erCW),      64'(m_cw));
    check("erCWValid",  64'(bus0.erCWValid), 64'(m_valid));
    check("endMsgOut",  64'(bus0.endMsgOut), 64'(m_end));
    check("armed",      64'(bus0.armed),     64'(m_armed));
    check("injCount",   64'(bus0.injCount),  64'(e16));
    check("injCount4",  64'(bus4.injCount),  64'(e4));
    check("erCW_w4",    64'(bus4.erCW),      64'(m_cw));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    erLoad = 0; clrCount = 0; CWValid = 0; endMsgIn = 0; erIn = '0; CW = '0;
  endtask

  initial begin
    idle();
    mode = BYPASS;
    rst  = 1'b1;
    model_reset();
    #2 rst = 1'b0;
    #1;
    compare_all();
    check("reset injCount", 64'(bus0.injCount), 64'd0);
    repeat (2) tick();
    rst = 1'b1;

    // Single-bit fixed error on a known pattern
    mode = FIXED; erLoad = 1; erIn = 32'h0000_0001; tick(); idle();
    CWValid = 1; CW = 32'hA5A5_A5A5; tick();
    check("fixed erCW",     64'(bus0.erCW),      64'hA5A5_A5A4);
    check("fixed valid",    64'(bus0.erCWValid), 64'd1);
    check("fixed injCount", 64'(bus0.injCount),  64'd1);
    idle();

    // One-shot fires once then disarms
    mode = ONESHOT; erLoad = 1; erIn = 32'h8000_0000; clrCount = 1; tick(); idle();
    check("oneshot armed0", 64'(bus0.armed), 64'd1);
    CWValid = 1; CW = '0;
    tick();
    check("oneshot cw1",    64'(bus0.erCW),  64'h8000_0000);
    check("oneshot armed1", 64'(bus0.armed), 64'd0);
    tick();
    check("oneshot cw2",    64'(bus0.erCW),  64'h0);
    tick();
    check("oneshot cw3",    64'(bus0.erCW),  64'h0);
    check("oneshot cnt",    64'(bus0.injCount), 64'd1);
    idle();

    // Walking vector rotates left after each codeword
    mode = WALK; erLoad = 1; erIn = 32'h8000_0001; tick(); idle();
    CWValid = 1; CW = '0;
    tick(); check("walk cw1", 64'(bus0.erCW), 64'h8000_0001);
    tick(); check("walk cw2", 64'(bus0.erCW), 64'h0000_0003);
    tick(); check("walk cw3", 64'(bus0.erCW), 64'h0000_0006);
    idle();

    // Load in the same cycle as a codeword is seen only by the next one
    mode = FIXED; erLoad = 1; erIn = 32'h10; tick(); idle();
    CWValid = 1; CW = '0; erLoad = 1; erIn = 32'hFFFF_FFFF; tick();
    check("loadsame old", 64'(bus0.erCW), 64'h10);
    idle();
    CWValid = 1; CW = '0; tick();
    check("loadsame new", 64'(bus0.erCW), 64'hFFFF_FFFF);
    idle();

    // Narrow counter saturates, then clear beats a same-cycle increment
    clrCount = 1; tick(); idle();
    CWValid = 1; CW = 32'h1234_5678;
    repeat (20) tick();
    check("sat cnt4", 64'(bus4.injCount), 64'd15);
    clrCount = 1; tick();
    check("clr cnt4", 64'(bus4.injCount), 64'd0);
    check("clr cnt16", 64'(bus0.injCount), 64'd0);
    idle();

    for (int i = 0; i < 1500; i++) begin
      mode     = errMode_t'($urandom_range(0, 3));
      CWValid  = ($urandom_range(0, 4) != 0);
      CW       = $urandom;
      endMsgIn = ($urandom_range(0, 3) == 0);
      erLoad   = ($urandom_range(0, 7) == 0);
      erIn     = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
      clrCount = ($urandom_range(0, 63) == 0);
      tick();
    end
    idle();

    // Asynchronous reset in the middle of a stream
    mode = FIXED; erLoad = 1; erIn = 32'h3; tick(); idle();
    CWValid = 1; CW = 32'hCAFE_0000; endMsgIn = 1; tick();
    check("pre-rst end", 64'(bus0.endMsgOut), 64'd1);
    CW = 32'h0BAD_F00D;
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("async erCW",  64'(bus0.erCW),      64'd0);
    check("async valid", 64'(bus0.erCWValid), 64'd0);
    check("async end",   64'(bus0.endMsgOut), 64'd0);
    tick();
    idle();
    rst = 1'b1;
    tick();
    check("post-rst end", 64'(bus0.endMsgOut), 64'd0);
    CWValid = 1; CW = 32'h5555_AAAA; tick();
    check("post-rst cw",  64'(bus0.erCW),     64'h5555_AAAA);
    check("post-rst cnt", 64'(bus0.injCount), 64'd0);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/error_injector_param.md
ERROR_INJECTOR_PARAM -- requirements
Module: error_injector_param

Interface
REQ-001 Parameter CW_WIDTH, default 32, codeword width in bits (legal range 8..64).
REQ-002 Parameter CNT_WIDTH, default 16, width of the injection counter.
REQ-003 clk  input  1  master clock; all state updates on its rising edge.
REQ-004 rst  input  1  master reset, asynchronous assert, active-low (0 = reset).
REQ-005 erLoad  input  1  load erIn into the stored error vector this cycle.
REQ-006 erIn  input  CW_WIDTH  error vector from testbench/top.
REQ-007 mode  input  2  injection mode (errMode_t): BYPASS=0, FIXED=1, ONESHOT=2, WALK=3.
REQ-008 clrCount  input  1  synchronous clear of injCount.
REQ-009 CWValid  input  1  CW valid this cycle, from transmitter.
REQ-010 CW  input  CW_WIDTH  codeword from transmitter.
REQ-011 endMsgIn  input  1  end-of-message marker, qualified by CWValid.
REQ-012 erCW  output  CW_WIDTH  registered, possibly corrupted codeword.
REQ-013 erCWValid  output  1  erCW valid, one-cycle pulse per accepted CW.
REQ-014 endMsgOut  output  1  endMsgIn delayed, aligned with erCWValid.
REQ-015 injCount  output  CNT_WIDTH  count of codewords emitted with a nonzero applied error.
REQ-016 armed  output  1  ONESHOT vector pending.

Function
REQ-017 Latency fixed at 1 cycle: CW accepted at edge N appears on erCW with erCWValid=1 after edge N; no back-pressure, one CW accepted per cycle.
REQ-018 When CWValid=0, erCWValid and endMsgOut SHALL be 0 next cycle; erCW holds its last value.
REQ-019 Applied error E per accepted CW: BYPASS E=0; FIXED E=stored vector; ONESHOT E=stored vector if armed else 0; WALK E=stored vector; erCW = CW XOR E.
REQ-020 mode is sampled in the same cycle as CWValid; mode change takes effect on the next accepted CW with no flush.
REQ-021 erLoad writes stored vector from erIn at the edge; the CW accepted in the same cycle uses the previous stored vector (load visible next cycle).
REQ-022 ONESHOT: armed sets on erLoad; clears on the edge that applies it to an accepted CW; simultaneous erLoad and application leaves armed=1 (load wins).
REQ-023 WALK: after each accepted CW, stored vector rotates left by 1 (MSB to bit 0); simultaneous erLoad overrides rotation.
REQ-024 armed is ignored outside ONESHOT and not cleared by other modes.
REQ-025 injCount increments by 1 when an accepted CW has E != 0; saturates at all-ones (no wrap).
REQ-026 clrCount has priority over increment in the same cycle; result 0.
REQ-027 All outputs registered; no combinational path input-to-output.

Reset
REQ-028 rst=0 asynchronously forces erCW=0, erCWValid=0, endMsgOut=0, injCount=0, armed=0, stored vector=0.
REQ-029 Reset mid-operation discards any in-flight CW; first accepted CW after rst release emits per REQ-017.
REQ-030 Reset deassertion is synchronised externally; block needs no internal synchroniser.

Structure
REQ-031 Shared package crc_pkg SHALL hold errMode_t enum and default CW_WIDTH/CNT_WIDTH constants, shared with transmitter and receiver.
REQ-032 One sub-module sat_counter (parameter WIDTH; inc, clr inputs; saturating) SHALL implement injCount.
REQ-033 Compatible with topInterface errorInjectorV1 signal naming when CW_WIDTH=32.

Verification
REQ-034 Reset then FIXED, load 0x0000_0001, CW=0xA5A5_A5A5 valid -> next cycle erCW=0xA5A5_A5A4, erCWValid=1, injCount=1.
REQ-035 ONESHOT, load 0x8000_0000, three CWs 0x0 -> erCW 0x8000_0000, 0x0, 0x0; armed 1->0 after first; injCount=1.
REQ-036 WALK, load 0x8000_0001, CWs 0x0 x3 -> erCW 0x8000_0001, 0x0000_0003, 0x0000_0006.
REQ-037 erLoad 0xFFFF_FFFF same cycle as CW=0x0 in FIXED with old vector 0x10 -> erCW=0x10; next CW 0x0 -> 0xFFFF_FFFF.
REQ-038 CNT_WIDTH=4, 20 erroneous CWs -> injCount stops at 15; clrCount with CWValid same cycle -> 0.
REQ-039 rst low while CWValid=1 mid-stream -> all outputs 0 immediately without clk edge; endMsgIn pulse before reset never appears on endMsgOut.
